// File: rtl/img_row_arbiter.sv
// rtl/img_row_arbiter.sv - round-robin row-read arbiter for the shared single-port row memory
module img_row_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 9,
    parameter int DW   = 5120,
    parameter int ROWS = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    gnt,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_addr,
    input  logic [DW-1:0]      mem_rdata,
    output logic [NREQ-1:0]    rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               clamp_flag
);

    localparam int            LW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] MAX_ROW = AW'(ROWS - 1);
    localparam logic [AW:0]   ROW_LIM = (AW + 1)'(ROWS);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            clamp_flag_q, clamp_flag_d;
    logic [LW-1:0]   last_gnt_q, last_gnt_d;
    logic [NREQ-1:0] rd_valid_q, rd_valid_d;

    logic [NREQ-1:0] eligible;
    logic [LW-1:0]   idx;
    logic [LW-1:0]   win;
    logic            found;
    logic [AW-1:0]   win_addr;
    logic            over;

    // Round-robin pick starting after the last winner; a requester is masked in its own grant cycle
    always_comb begin
        eligible = arb_en ? (req & ~gnt_q) : '0;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LW'((int'(last_gnt_q) + k) % NREQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_addr = req_addr[win*AW +: AW];
        over     = ({1'b0, win_addr} >= ROW_LIM);

        gnt_d        = found ? (NREQ'(1) << win) : '0;
        mem_rd_en_d  = found;
        mem_addr_d   = found ? (over ? MAX_ROW : win_addr) : mem_addr_q;
        clamp_flag_d = found & over;
        last_gnt_d   = found ? win : last_gnt_q;
        // The grant vector doubles as the owner tag travelling with the read strobe
        rd_valid_d   = mem_rd_en_q ? gnt_q : '0;
    end

    // Pipeline registers; reset discards any read in flight
    always_ff @(posedge clk) begin
        if (rst_n) begin
            gnt_q        <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            clamp_flag_q <= 1'b0;
            last_gnt_q   <= LW'(NREQ - 1);
            rd_valid_q   <= '0;
        end else begin
            gnt_q        <= gnt_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            clamp_flag_q <= clamp_flag_d;
            last_gnt_q   <= last_gnt_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign clamp_flag = clamp_flag_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = mem_rdata;

endmodule

// File: doc/img_row_arbiter.md
IMG_ROW_ARBITER -- requirements
Module: img_row_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of row requesters (blur engines 3x3, 5x5_1, 5x5_2, 7x7).
REQ-002 Parameter AW, 9, row address width.
REQ-003 Parameter DW, 5120, row data width (640 pixels x 8 bits).
REQ-004 Parameter ROWS, 480, number of valid image rows.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-high reset; asserted = 1; port name follows the codebase port convention.
REQ-007 arb_en  input  1  1 = new grants allowed; 0 = no new grants.
REQ-008 req  input  NREQ  per-requester row-read request, level, held until granted.
REQ-009 req_addr  input  NREQ*AW  row address; requester i uses bits [i*AW +: AW].
REQ-010 gnt  output  NREQ  registered one-hot grant, one-cycle pulse.
REQ-011 mem_rd_en  output  1  registered read strobe to the single-port row memory.
REQ-012 mem_addr  output  AW  registered row address to the memory.
REQ-013 mem_rdata  input  DW  memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 rd_valid  output  NREQ  one-hot; marks the owner of rd_data.
REQ-015 rd_data  output  DW  mem_rdata passed through combinationally.
REQ-016 clamp_flag  output  1  registered; pulses with mem_rd_en when the address was clamped.

Function
REQ-017 In cycle t, eligible = req & ~gnt when arb_en = 1; a granted requester is masked in its own gnt cycle, so a held req is not granted twice.
REQ-018 Round-robin: search starts at last_gnt+1 mod NREQ, and the first eligible index wins.
REQ-019 Winner w at t: at t+1, gnt[w] = 1, mem_rd_en = 1, and mem_addr = the clamped req_addr of w; last_gnt <= w.
REQ-020 No eligible requester, or arb_en = 0: gnt = 0, mem_rd_en = 0, and last_gnt holds.
REQ-021 Clamp: a request with req_addr >= ROWS issues mem_addr = ROWS-1 (479) and raises clamp_flag in the same cycle as mem_rd_en; the data is still returned.
REQ-022 Return path: an owner tag is registered with mem_rd_en; rd_valid[tag] = 1 exactly 1 cycle after mem_rd_en, i.e. 2 cycles after the request was sampled.
REQ-023 Throughput: one grant per cycle maximum; back-to-back grants to different requesters are pipelined without bubbles.
REQ-024 Fairness: a continuously requesting requester is granted within NREQ grant cycles of raising req.
REQ-025 Requester contract: deassert req, or present a new address, in the cycle after gnt is seen; a still-high req after that cycle is a new request.
REQ-026 Deasserting arb_en does not cancel in-flight reads; an outstanding rd_valid still fires.
REQ-027 req dropped before grant: withdrawn, no grant, no error.

Reset
REQ-028 While rst_n = 1 at a clock edge: gnt = 0, mem_rd_en = 0, mem_addr = 0, clamp_flag = 0, rd_valid = 0, last_gnt = NREQ-1 (so requester 0 has first priority), owner-valid pipeline cleared.
REQ-029 Reset mid-operation: in-flight reads are discarded; no rd_valid is issued in the cycle after reset deasserts.
REQ-030 The first grant is possible 2 edges after rst_n falls: eligibility is sampled at the first edge, and gnt appears at the second.

Verification
REQ-031 Single request: after reset, req = 0001, addr0 = 5 -> cycle+1 gnt = 0001, mem_rd_en = 1, mem_addr = 5; cycle+2 rd_valid = 0001, rd_data = mem row 5.
REQ-032 All four requesting continuously, addresses 10/20/30/40 -> gnt sequence 0001, 0010, 0100, 1000, 0001 ...; mem_addr 10, 20, 30, 40, with no idle cycle.
REQ-033 Clamp: req = 0100, addr2 = 481 -> mem_addr = 479, clamp_flag = 1 for 1 cycle, rd_valid = 0100 the next cycle.
REQ-034 Held-req masking: requester 1 keeps req high with addr 7 for 3 cycles, others idle -> gnt[1] pulses in alternate cycles, never two consecutive cycles.
REQ-035 arb_en dropped the cycle after a grant to requester 3 -> rd_valid = 1000 still fires; no further gnt until arb_en = 1; the next grant goes to requester 0 when all request.
REQ-036 Reset asserted the cycle mem_rd_en = 1 -> next cycle rd_valid = 0, all outputs 0; after release, requester 0 wins a 4-way tie.
